// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Parametrised GPR + HI/LO register file with busy scoreboard.
//            Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int HILO_EN  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_we,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              hi_re,
    input  logic              lo_re,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hilo_rdata,
    output logic              hilo_busy,
    input  logic              hilo_rsv
);

    logic [DATA_W-1:0] w_reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;

    // One storage slot per implemented register; addresses outside the
    // implemented range never match any slot, so they are ignored naturally.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign w_reg_q[i] = '0;
                assign w_busy[i]  = 1'b0;
            end else begin : g_gpr
                logic [DATA_W-1:0] r_q;
                logic              r_b;
                logic              w_wr_hit;
                logic              w_rsv_hit;

                assign w_wr_hit  = we && (waddr == ADDR_W'(i));
                assign w_rsv_hit = rsv_we && (rsv_addr == ADDR_W'(i));

                always_ff @(posedge clk) begin
                    if (!resetn) begin
                        r_q <= '0;
                        r_b <= 1'b0;
                    end else begin
                        if (w_wr_hit)
                            r_q <= wdata;
                        // A fresh reservation outranks the completing write.
                        if (w_rsv_hit)
                            r_b <= 1'b1;
                        else if (w_wr_hit)
                            r_b <= 1'b0;
                    end
                end

                assign w_reg_q[i] = r_q;
                assign w_busy[i]  = r_b;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);
    logic w_wr_ok;
    logic w_rsv_on_w;
    assign w_wr_ok    = we && (waddr != '0) && ({1'b0, waddr} < c_num_regs);
    assign w_rsv_on_w = rsv_we && (rsv_addr == waddr);
`endif

    always_comb begin
        rdata1 = '0;
        rbusy1 = 1'b0;
        rdata2 = '0;
        rbusy2 = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                rdata1 = w_reg_q[i];
                rbusy1 = w_busy[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                rdata2 = w_reg_q[i];
                rbusy2 = w_busy[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (raddr1 == waddr)) begin
            rdata1 = wdata;
            rbusy1 = w_rsv_on_w;
        end
        if (w_wr_ok && (raddr2 == waddr)) begin
            rdata2 = wdata;
            rbusy2 = w_rsv_on_w;
        end
`endif
    end

    generate
        if (HILO_EN != 0) begin : g_hilo
            logic [DATA_W-1:0] r_hi;
            logic [DATA_W-1:0] r_lo;
            logic              r_hilo_busy;
            logic [DATA_W-1:0] w_hi;
            logic [DATA_W-1:0] w_lo;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_hi        <= '0;
                    r_lo        <= '0;
                    r_hilo_busy <= 1'b0;
                end else begin
                    if (hi_we)
                        r_hi <= hi_wdata;
                    if (lo_we)
                        r_lo <= lo_wdata;
                    if (hilo_rsv)
                        r_hilo_busy <= 1'b1;
                    else if (hi_we || lo_we)
                        r_hilo_busy <= 1'b0;
                end
            end

`ifdef REGFILE_BYPASS_EN
            assign w_hi      = hi_we ? hi_wdata : r_hi;
            assign w_lo      = lo_we ? lo_wdata : r_lo;
            assign hilo_busy = ((hi_we || lo_we) && !hilo_rsv) ? 1'b0 : r_hilo_busy;
`else
            assign w_hi      = r_hi;
            assign w_lo      = r_lo;
            assign hilo_busy = r_hilo_busy;
`endif
            assign hilo_rdata = hi_re ? w_hi : (lo_re ? w_lo : '0);
        end else begin : g_no_hilo
            assign hilo_rdata = '0;
            assign hilo_busy  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire
